// File: rtl/control.sv
// SD-card SPI-mode boot sequencer: card init, then one CMD17 block read whose first 32 bits go to mem_data_o.
// Optional build macro CONTROL_TIMEOUT_EN bounds the CMD55/ACMD41 retry loop to ACMD41_MAX_TRIES pairs.
module control #(
  parameter logic [1:0] SLOW_DIV         = 2'b11,
  parameter logic [1:0] FAST_DIV         = 2'b00,
  parameter int         ACMD41_MAX_TRIES = 255
) (
  input  logic        control_clk_i,
  input  logic        control_rst_i,
  input  logic [31:0] sd_address_i,
  input  logic [47:0] spi_data_i,
  input  logic        spi_SCK_i,
  input  logic        spi_done_i,
  output logic        spi_rst_o,
  output logic        spi_fbo_o,
  output logic        spi_start_o,
  output logic [47:0] instruction_sd_o,
  output logic [1:0]  clock_divider_o,
  output logic [31:0] mem_data_o
);

  typedef enum logic [3:0] {
    IDLE, DUMMY, CMD0, CMD8, CMD55, ACMD41, CMD17, DATA, DONE, ERROR
  } state_t;

  state_t      state, state_n;
  logic        frame_gap, frame_gap_n;   // waiting for done to fall before the next frame
  logic        spi_rst_n, spi_start_n;
  logic [47:0] instr_n, frame_cmd;
  logic [1:0]  div_n;
  logic [31:0] mem_n;
  logic        done_s1, done_s2, done_d, done_rise;
  logic        sck_s1, sck_s2;
  logic [7:0]  r1;

`ifdef CONTROL_TIMEOUT_EN
  localparam logic [7:0] MAX_TRIES = 8'(ACMD41_MAX_TRIES);
  logic [7:0] tries, tries_n;
`endif

  assign spi_fbo_o = 1'b1;
  assign r1        = spi_data_i[7:0];
  assign done_rise = done_s2 & ~done_d;

  // NOTE: the done synchroniser resets high so a done level that is already
  // high when the first frame goes out can never look like a fresh rising edge.
  always_ff @(posedge control_clk_i or negedge control_rst_i) begin
    if (!control_rst_i) begin
      done_s1 <= 1'b1;
      done_s2 <= 1'b1;
      done_d  <= 1'b1;
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
    end else begin
      done_s1 <= spi_done_i;
      done_s2 <= done_s1;
      done_d  <= done_s2;
      sck_s1  <= spi_SCK_i;
      sck_s2  <= sck_s1;
    end
  end

  // SCK is status only, and the upper response bits carry nothing we need.
  logic unused_status;
`ifdef CONTROL_TIMEOUT_EN
  assign unused_status = ^{spi_data_i[47:32], sck_s2};
`else
  assign unused_status = ^{spi_data_i[47:32], sck_s2, 32'(ACMD41_MAX_TRIES)};
`endif

  always_comb begin
    frame_cmd = 48'hFFFF_FFFF_FFFF;
    case (state)
      CMD0:    frame_cmd = 48'h40_0000_0000_95;
      CMD8:    frame_cmd = 48'h48_0000_01AA_87;
      CMD55:   frame_cmd = 48'h77_0000_0000_65;
      ACMD41:  frame_cmd = 48'h69_4000_0000_77;
      CMD17:   frame_cmd = {8'h51, sd_address_i, 8'hFF};
      default: frame_cmd = 48'hFFFF_FFFF_FFFF;
    endcase
  end

  // NOTE: every next-value is defaulted to its current value first, so no
  // path through the case can leave a variable unassigned and infer a latch.
  always_comb begin
    state_n     = state;
    frame_gap_n = frame_gap;
    spi_rst_n   = spi_rst_o;
    spi_start_n = spi_start_o;
    instr_n     = instruction_sd_o;
    div_n       = clock_divider_o;
    mem_n       = mem_data_o;
`ifdef CONTROL_TIMEOUT_EN
    tries_n     = tries;
`endif
    case (state)
      IDLE: begin
        spi_rst_n = 1'b0;
        state_n   = DUMMY;
      end
      DONE: spi_start_n = 1'b0;
      ERROR: begin
        spi_rst_n   = 1'b1;
        spi_start_n = 1'b0;
      end
      default: begin
        if (frame_gap) begin
          if (!done_s2) frame_gap_n = 1'b0;
        end else if (!spi_start_o) begin
          instr_n     = frame_cmd;
          spi_start_n = 1'b1;
        end else if (done_rise) begin
          spi_start_n = 1'b0;
          frame_gap_n = 1'b1;
          case (state)
            DUMMY:  state_n = CMD0;
            CMD0:   state_n = r1[7] ? ERROR : CMD8;
            CMD8:   state_n = r1[7] ? ERROR : CMD55;
            CMD55:  state_n = ACMD41;
            ACMD41: begin
              if (r1 == 8'h00) begin
                div_n   = FAST_DIV;
                state_n = CMD17;
              end else begin
`ifdef CONTROL_TIMEOUT_EN
                tries_n = 8'(tries + 8'd1);
                state_n = (tries_n == MAX_TRIES) ? ERROR : CMD55;
`else
                state_n = CMD55;
`endif
              end
            end
            CMD17:  state_n = (r1 == 8'h00) ? DATA : ERROR;
            DATA: begin
              mem_n   = spi_data_i[31:0];
              state_n = DONE;
            end
            default: state_n = ERROR;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge control_clk_i or negedge control_rst_i) begin
    if (!control_rst_i) begin
      state            <= IDLE;
      frame_gap        <= 1'b0;
      spi_rst_o        <= 1'b1;
      spi_start_o      <= 1'b0;
      instruction_sd_o <= 48'hFFFF_FFFF_FFFF;
      clock_divider_o  <= SLOW_DIV;
      mem_data_o       <= 32'h0;
`ifdef CONTROL_TIMEOUT_EN
      tries            <= 8'h0;
`endif
    end else begin
      state            <= state_n;
      frame_gap        <= frame_gap_n;
      spi_rst_o        <= spi_rst_n;
      spi_start_o      <= spi_start_n;
      instruction_sd_o <= instr_n;
      clock_divider_o  <= div_n;
      mem_data_o       <= mem_n;
`ifdef CONTROL_TIMEOUT_EN
      tries            <= tries_n;
`endif
    end
  end

endmodule

// File: tb/tb_control.sv
// Bench for control: an SPI-master model answers frames from per-case card responses;
// a frame-list model derived from the boot sequence rules supplies the expectations.
module tb_control;

  localparam logic [1:0] SLOW = 2'b11;
  localparam logic [1:0] FAST = 2'b00;
`ifdef CONTROL_TIMEOUT_EN
  localparam int MAX_TRIES = 4;
  localparam bit TIMEOUT   = 1'b1;
`else
  localparam int MAX_TRIES = 255;
  localparam bit TIMEOUT   = 1'b0;
`endif
  localparam logic [47:0] ONES = 48'hFFFF_FFFF_FFFF;

  logic        control_clk_i = 1'b0;
  logic        control_rst_i;
  logic [31:0] sd_address_i;
  logic [47:0] spi_data_i;
  logic        spi_SCK_i = 1'b0;
  logic        spi_done_i;
  logic        spi_rst_o, spi_fbo_o, spi_start_o;
  logic [47:0] instruction_sd_o;
  logic [1:0]  clock_divider_o;
  logic [31:0] mem_data_o;

  control #(.SLOW_DIV(SLOW), .FAST_DIV(FAST), .ACMD41_MAX_TRIES(MAX_TRIES)) dut (
    .control_clk_i(control_clk_i), .control_rst_i(control_rst_i),
    .sd_address_i(sd_address_i), .spi_data_i(spi_data_i), .spi_SCK_i(spi_SCK_i),
    .spi_done_i(spi_done_i), .spi_rst_o(spi_rst_o), .spi_fbo_o(spi_fbo_o),
    .spi_start_o(spi_start_o), .instruction_sd_o(instruction_sd_o),
    .clock_divider_o(clock_divider_o), .mem_data_o(mem_data_o));

  always #5  control_clk_i = ~control_clk_i;
  always #20 spi_SCK_i     = ~spi_SCK_i;

  typedef struct packed { logic [47:0] frame; logic [1:0] div; } frame_t;
  frame_t log_q[$];
  frame_t exp_q[$];

  // Card responses for the current case.
  logic [7:0]  s_cmd0, s_cmd8, s_fail_r1, s_cmd17;
  int          s_fails;
  logic [31:0] s_data;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // SPI master model: one frame per start request, done held 8 clocks (2 SCK).
  initial begin
    int phase, cnt, acmd_cnt;
    logic seen17;
    logic [47:0] cur;
    logic [7:0] r;
    phase = 0; cnt = 0; acmd_cnt = 0; seen17 = 1'b0; cur = '0;
    spi_done_i = 1'b0;
    spi_data_i = '0;
    forever begin
      @(posedge control_clk_i);
      #1;
      if (control_rst_i !== 1'b1) begin
        phase = 0; acmd_cnt = 0; seen17 = 1'b0;
        spi_done_i = 1'b0;
        spi_data_i = '0;
        log_q.delete();
      end else begin
        case (phase)
          0: if (spi_start_o) begin
            cur = instruction_sd_o;
            log_q.push_back('{frame: cur, div: clock_divider_o});
            cnt = $urandom_range(2, 8);
            phase = 1;
          end
          1: if (cnt == 0) begin
            r = 8'($urandom);
            case (cur[47:40])
              8'h40: r = s_cmd0;
              8'h48: r = s_cmd8;
              8'h69: begin r = (acmd_cnt < s_fails) ? s_fail_r1 : 8'h00; acmd_cnt++; end
              8'h51: begin r = s_cmd17; seen17 = 1'b1; end
              8'hFF: r = seen17 ? s_data[7:0] : 8'($urandom);
              default: ;
            endcase
            if (cur[47:40] == 8'hFF && seen17) spi_data_i = {16'($urandom), s_data};
            else spi_data_i = {32'($urandom), 8'($urandom), r};
            spi_done_i = 1'b1;
            cnt = 8;
            phase = 2;
          end else cnt--;
          2: begin
            cnt--;
            if (cnt == 0) begin
              spi_done_i = 1'b0;
              spi_data_i = '0;
              phase = 3;
            end
          end
          default: if (!spi_start_o) phase = 0;
        endcase
      end
    end
  end

  // Expected frame list and final outputs, straight from the boot sequence rules.
  task automatic build_model(output logic err, output logic [31:0] mem, output logic [1:0] div);
    int pairs;
    logic timed_out;
    exp_q.delete();
    err = 1'b0; mem = '0; div = SLOW;
    exp_q.push_back('{frame: ONES, div: SLOW});
    exp_q.push_back('{frame: 48'h40_0000_0000_95, div: SLOW});
    if (s_cmd0[7]) begin err = 1'b1; return; end
    exp_q.push_back('{frame: 48'h48_0000_01AA_87, div: SLOW});
    if (s_cmd8[7]) begin err = 1'b1; return; end
    pairs = s_fails + 1;
    timed_out = TIMEOUT && (s_fails >= MAX_TRIES);
    if (timed_out) pairs = MAX_TRIES;
    for (int i = 0; i < pairs; i++) begin
      exp_q.push_back('{frame: 48'h77_0000_0000_65, div: SLOW});
      exp_q.push_back('{frame: 48'h69_4000_0000_77, div: SLOW});
    end
    if (timed_out) begin err = 1'b1; return; end
    div = FAST;
    exp_q.push_back('{frame: {8'h51, sd_address_i, 8'hFF}, div: FAST});
    if (s_cmd17 != 8'h00) begin err = 1'b1; return; end
    exp_q.push_back('{frame: ONES, div: FAST});
    mem = s_data;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " rst"},   64'(spi_rst_o), 64'd1);
    check({tag, " fbo"},   64'(spi_fbo_o), 64'd1);
    check({tag, " start"}, 64'(spi_start_o), 64'd0);
    check({tag, " instr"}, 64'(instruction_sd_o), 64'(ONES));
    check({tag, " div"},   64'(clock_divider_o), 64'(SLOW));
    check({tag, " mem"},   64'(mem_data_o), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge control_clk_i);
    control_rst_i = 1'b0;
    repeat (2) @(negedge control_clk_i);
    check_reset_values({tag, " in reset"});
    control_rst_i = 1'b1;
    @(negedge control_clk_i);
    check({tag, " rst released"}, 64'(spi_rst_o), 64'd0);
  endtask

  task automatic finish_case(input string tag, input int exp_frames, input logic exp_err,
                             input logic [31:0] exp_mem, input logic [1:0] exp_div);
    int waited;
    waited = 0;
    while (log_q.size() < exp_q.size() && waited < 4000) begin
      @(negedge control_clk_i);
      waited++;
    end
    repeat (80) @(negedge control_clk_i);
    check({tag, " frame count"}, 64'(log_q.size()), 64'(exp_frames));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < log_q.size())
        check($sformatf("%s frame%0d", tag, i), 64'(log_q[i]), 64'(exp_q[i]));
    check({tag, " end start"}, 64'(spi_start_o), 64'd0);
    check({tag, " end rst"},   64'(spi_rst_o), 64'(exp_err));
    check({tag, " end mem"},   64'(mem_data_o), 64'(exp_mem));
    check({tag, " end div"},   64'(clock_divider_o), 64'(exp_div));
    check({tag, " end fbo"},   64'(spi_fbo_o), 64'd1);
  endtask

  typedef struct {
    logic [7:0]  cmd0, cmd8;
    int          fails;
    logic [7:0]  fail_r1, cmd17;
    logic [31:0] addr, data;
    logic        exp_err;
    logic [31:0] exp_mem;
    int          exp_frames;
    logic [1:0]  exp_div;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic m_err;
    logic [31:0] m_mem;
    logic [1:0] m_div;
    int waited;

    control_rst_i = 1'b0;
    sd_address_i  = '0;

    vecs[0] = '{8'h00, 8'h00, 0,  8'h01, 8'h00, 32'hF1F1AF01, 32'h0,        1'b0, 32'h0,        7,  FAST};
    vecs[1] = '{8'h00, 8'h00, 0,  8'h01, 8'h00, 32'hF1F1AF01, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 7,  FAST};
    vecs[2] = '{8'h00, 8'h00, 3,  8'h01, 8'h00, 32'h00000200, 32'h12345678, 1'b0, 32'h12345678, 13, FAST};
    vecs[3] = '{8'h80, 8'h00, 0,  8'h01, 8'h00, 32'h00000000, 32'h11111111, 1'b1, 32'h0,        2,  SLOW};
    vecs[4] = '{8'h01, 8'h85, 0,  8'h01, 8'h00, 32'h00000000, 32'h22222222, 1'b1, 32'h0,        3,  SLOW};
    vecs[5] = '{8'h00, 8'h00, 0,  8'h01, 8'h05, 32'h00001000, 32'h33333333, 1'b1, 32'h0,        6,  FAST};
    vecs[6] = '{8'h01, 8'h01, 1,  8'hC1, 8'h00, 32'h7FFF_FFFF, 32'hA5A55A5A, 1'b0, 32'hA5A55A5A, 9,  FAST};
`ifdef CONTROL_TIMEOUT_EN
    vecs[7] = '{8'h00, 8'h00, 10, 8'h01, 8'h00, 32'h00000040, 32'h0BADF00D, 1'b1, 32'h0,        11, SLOW};
`else
    vecs[7] = '{8'h00, 8'h00, 10, 8'h01, 8'h00, 32'h00000040, 32'h0BADF00D, 1'b0, 32'h0BADF00D, 27, FAST};
`endif

    for (int t = 0; t < 8; t++) begin
      s_cmd0 = vecs[t].cmd0; s_cmd8 = vecs[t].cmd8; s_fails = vecs[t].fails;
      s_fail_r1 = vecs[t].fail_r1; s_cmd17 = vecs[t].cmd17; s_data = vecs[t].data;
      sd_address_i = vecs[t].addr;
      build_model(m_err, m_mem, m_div);
      do_reset($sformatf("vec%0d", t));
      finish_case($sformatf("vec%0d", t), vecs[t].exp_frames, vecs[t].exp_err,
                  vecs[t].exp_mem, vecs[t].exp_div);
      if (t == 0 && log_q.size() > 5)
        check("vec0 cmd17 frame", 64'(log_q[5].frame), 64'(48'h51F1F1AF01FF));
    end

    // Reset while the CMD8 request is pending, then a full restart from DUMMY.
    s_cmd0 = 8'h00; s_cmd8 = 8'h00; s_fails = 0; s_fail_r1 = 8'h01; s_cmd17 = 8'h00;
    s_data = 32'hCAFE_F00D; sd_address_i = 32'hF1F1AF01;
    build_model(m_err, m_mem, m_div);
    do_reset("midrst");
    waited = 0;
    while (!(spi_start_o && instruction_sd_o[47:40] == 8'h48) && waited < 2000) begin
      @(negedge control_clk_i);
      waited++;
    end
    check("midrst cmd8 reached", 64'(spi_start_o && instruction_sd_o[47:40] == 8'h48), 64'd1);
    #1 control_rst_i = 1'b0;
    #1 check_reset_values("midrst async");
    repeat (2) @(negedge control_clk_i);
    control_rst_i = 1'b1;
    @(negedge control_clk_i);
    check("midrst released", 64'(spi_rst_o), 64'd0);
    finish_case("midrst", 7, 1'b0, 32'hCAFE_F00D, FAST);

    for (int n = 0; n < 8; n++) begin
      s_cmd0    = ($urandom_range(0, 3) == 0) ? (8'h80 | 8'($urandom)) : (8'($urandom) & 8'h7F);
      s_cmd8    = ($urandom_range(0, 3) == 0) ? (8'h80 | 8'($urandom)) : (8'($urandom) & 8'h7F);
      s_fails   = $urandom_range(0, 5);
      s_fail_r1 = 8'($urandom_range(1, 255));
      s_cmd17   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      s_data    = $urandom;
      sd_address_i = $urandom;
      build_model(m_err, m_mem, m_div);
      do_reset($sformatf("rnd%0d", n));
      finish_case($sformatf("rnd%0d", n), exp_q.size(), m_err, m_mem, m_div);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
